// File: rtl/key_pad_entry.sv
// 4x4 matrix keypad scanner with debounce and signed 6-digit numeric entry.
module key_pad_entry #(
  parameter int unsigned SCAN_DIV = 5000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [19:0] entry,
  output logic        entry_sign,
  output logic [2:0]  digit_cnt,
  output logic [19:0] result,
  output logic        result_sign,
  output logic        result_valid
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STAB_W = 4;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);

  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd14;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        r;
  logic [15:0]       frame_acc;
  logic [15:0]       prev_frame;
  logic [15:0]       held_frame;
  logic [STAB_W-1:0] stab;

  logic              slot_end;
  logic              frame_end;
  logic [3:0]        col_hit;
  logic [15:0]       col_bits;
  logic [15:0]       frame_now;
  logic [4:0]        pop;
  logic [3:0]        key_idx;
  logic              is_single;
  logic              is_none;
  logic [STAB_W-1:0] stab_nxt;
  logic              stab_hit;

  logic              is_digit;
  logic [3:0]        dval;
  logic [19:0]       entry_x10;
  logic [19:0]       entry_div10;

  // Slot timing, the frame as it stands including the current row sample, and its class
  always_comb begin
    slot_end  = (div_cnt == DIV_LAST);
    frame_end = slot_end && (r == 2'd3);
    col_hit   = ~col;
    col_bits  = {12'd0, col_hit} << {r, 2'b00};
    frame_now = frame_acc | col_bits;
    pop       = '0;
    key_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + 5'(frame_now[i]);
      if (frame_now[i]) key_idx = 4'(i);
    end
    is_single = (pop == 5'd1);
    is_none   = (frame_now == 16'd0);
    if (frame_now == prev_frame)
      stab_nxt = (stab >= STAB_MAX) ? STAB_MAX : stab + STAB_W'(1);
    else
      stab_nxt = STAB_W'(1);
    stab_hit = (stab_nxt >= STAB_MAX);
  end

  // Row scanning, frame capture and debounce state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      r          <= 2'd0;
      row        <= 4'b1110;
      frame_acc  <= '0;
      prev_frame <= '0;
      held_frame <= '0;
      stab       <= '0;
      state      <= IDLE;
      key_code   <= '0;
      key_valid  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (slot_end) begin
        div_cnt   <= '0;
        r         <= r + 2'd1;
        row       <= {row[2:0], row[3]};
        frame_acc <= frame_end ? 16'd0 : frame_now;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (frame_end) begin
        prev_frame <= frame_now;
        stab       <= stab_nxt;
        case (state)
          IDLE:         if (is_single) state <= PRESS_WAIT;
          PRESS_WAIT: begin
            if (!is_single) begin
              state <= IDLE;
            end else if (stab_hit) begin
              state      <= HELD;
              held_frame <= frame_now;
              key_code   <= key_idx;
              key_valid  <= 1'b1;
            end
          end
          HELD:         if (frame_now != held_frame) state <= RELEASE_WAIT;
          RELEASE_WAIT: if (is_none && stab_hit) state <= IDLE;
          default:      state <= IDLE;
        endcase
      end
    end
  end

  // Key index to digit value map
  always_comb begin
    is_digit = 1'b1;
    dval     = 4'd0;
    case (key_code)
      4'd0:    dval = 4'd1;
      4'd1:    dval = 4'd2;
      4'd2:    dval = 4'd3;
      4'd4:    dval = 4'd4;
      4'd5:    dval = 4'd5;
      4'd6:    dval = 4'd6;
      4'd8:    dval = 4'd7;
      4'd9:    dval = 4'd8;
      4'd10:   dval = 4'd9;
      4'd13:   dval = 4'd0;
      default: is_digit = 1'b0;
    endcase
    entry_x10   = 20'(24'(entry) * 24'd10 + 24'(dval));
    entry_div10 = entry / 20'd10;
  end

  // Entry editing, applied the cycle after a key is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry        <= '0;
      entry_sign   <= 1'b0;
      digit_cnt    <= '0;
      result       <= '0;
      result_sign  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (key_valid) begin
        if (is_digit) begin
          if (digit_cnt < 3'd6) begin
            entry     <= entry_x10;
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else begin
          case (key_code)
            KEY_A: entry_sign <= ~entry_sign;
            KEY_B: begin
              if (digit_cnt != 3'd0) begin
                entry     <= entry_div10;
                digit_cnt <= digit_cnt - 3'd1;
              end
            end
            KEY_C: begin
              entry      <= '0;
              entry_sign <= 1'b0;
              digit_cnt  <= '0;
            end
            KEY_HASH: begin
              result       <= entry;
              result_sign  <= entry_sign;
              result_valid <= 1'b1;
              entry        <= '0;
              entry_sign   <= 1'b0;
              digit_cnt    <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_key_pad_entry.sv
// Scoreboard bench for key_pad_entry: keypad model, behavioural entry model, decoupled monitor.
module tb_key_pad_entry;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [19:0] entry;
  logic        entry_sign;
  logic [2:0]  digit_cnt;
  logic [19:0] result;
  logic        result_sign;
  logic        result_valid;

  logic [15:0] pressed = 16'd0;

  key_pad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid),
    .entry(entry), .entry_sign(entry_sign), .digit_cnt(digit_cnt),
    .result(result), .result_sign(result_sign), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      if (!row[rr])
        for (int c = 0; c < 4; c++)
          if (pressed[rr*4+c]) col[c] = 1'b0;
  end

  typedef struct { int e; bit s; int n; } st_t;

  int  dmap [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int  m_entry = 0;
  bit  m_sign  = 0;
  int  m_cnt   = 0;
  int  exp_key_q [$];
  st_t exp_st_q  [$];
  st_t exp_res_q [$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic void unexpected(string name);
    n_total++;
    $display("FAIL %s: got unexpected pulse, expected none", name);
  endfunction

  // Reference model of what an accepted key does to the entry
  function automatic void model_key(int idx);
    int d;
    d = dmap[idx];
    if (d >= 0) begin
      if (m_cnt < 6) begin m_entry = m_entry * 10 + d; m_cnt++; end
    end else if (idx == 3) begin
      m_sign = !m_sign;
    end else if (idx == 7) begin
      if (m_cnt > 0) begin m_entry = m_entry / 10; m_cnt--; end
    end else if (idx == 11) begin
      m_entry = 0; m_sign = 0; m_cnt = 0;
    end else if (idx == 14) begin
      exp_res_q.push_back('{m_entry, m_sign, 0});
      m_entry = 0; m_sign = 0; m_cnt = 0;
    end
    exp_key_q.push_back(idx);
    exp_st_q.push_back('{m_entry, m_sign, m_cnt});
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int idx, int hold, int rel);
    cycles($urandom_range(0, 15));
    model_key(idx);
    pressed = 16'd1 << idx;
    cycles(hold * FRAME);
    pressed = 16'd0;
    cycles(rel * FRAME);
  endtask

  // Monitor: compare DUT outputs with the queued expectations as they appear
  initial begin
    bit  pend;
    int  k;
    st_t s;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        s = exp_st_q.pop_front();
        check("entry", int'(entry), s.e);
        check("entry_sign", int'(entry_sign), int'(s.s));
        check("digit_cnt", int'(digit_cnt), s.n);
      end
      if (result_valid) begin
        if (exp_res_q.size() == 0) unexpected("result_valid");
        else begin
          s = exp_res_q.pop_front();
          check("result", int'(result), s.e);
          check("result_sign", int'(result_sign), int'(s.s));
        end
      end
      if (key_valid) begin
        if (exp_key_q.size() == 0) unexpected("key_valid");
        else begin
          k = exp_key_q.pop_front();
          check("key_code", int'(key_code), k);
          pend = 1;
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] er;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst key_code", int'(key_code), 0);
    check("rst key_valid", int'(key_valid), 0);
    check("rst entry", int'(entry), 0);
    check("rst entry_sign", int'(entry_sign), 0);
    check("rst digit_cnt", int'(digit_cnt), 0);
    check("rst result", int'(result), 0);
    check("rst result_sign", int'(result_sign), 0);
    check("rst result_valid", int'(result_valid), 0);
    for (int i = 0; i < 16; i++) begin
      er = 4'b0001 << (i / 4);
      er = ~er;
      check("row scan", int'(row), int'(er));
      @(negedge clk);
    end

    // Single press of digit 5
    press(5, 4, 3);
    check("single entry", int'(entry), 5);

    // Digit limit: the seventh digit is ignored
    press(11, 4, 3);
    foreach (dmap[i]) ;
    press(0, 4, 3); press(1, 4, 3); press(2, 4, 3); press(4, 4, 3);
    press(5, 4, 3); press(6, 4, 3); press(8, 4, 3);
    check("limit entry", int'(entry), 123456);
    check("limit digit_cnt", int'(digit_cnt), 6);

    // Sign, backspace, Enter
    press(11, 4, 3);
    press(0, 4, 3); press(1, 4, 3); press(13, 4, 3);
    press(3, 4, 3); press(7, 4, 3); press(14, 4, 3);
    check("enter result", int'(result), 12);
    check("enter result_sign", int'(result_sign), 1);
    check("enter entry", int'(entry), 0);

    // Bounce then ghosting: nothing may be accepted
    pressed = 16'd1 << 9;  cycles(FRAME);
    pressed = 16'd0;       cycles(FRAME);
    pressed = 16'd1 << 9;  cycles(FRAME);
    pressed = 16'd0;       cycles(3 * FRAME);
    pressed = 16'h0021;    cycles(4 * FRAME);
    pressed = 16'd0;       cycles(3 * FRAME);

    // Reset while a key is held
    press(4, 4, 3); press(1, 4, 3);
    check("pre-reset entry", int'(entry), 42);
    model_key(8);
    pressed = 16'd1 << 8;
    cycles(4 * FRAME);
    rst_n = 1'b0;
    m_entry = 0; m_sign = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-rst entry", int'(entry), 0);
    check("mid-rst digit_cnt", int'(digit_cnt), 0);
    check("mid-rst key_code", int'(key_code), 0);
    check("mid-rst result", int'(result), 0);
    check("mid-rst row", int'(row), 14);
    model_key(8);
    cycles(4 * FRAME);
    pressed = 16'd0;
    cycles(3 * FRAME);
    check("re-accept entry", int'(entry), 7);

    // Randomized key sequence
    for (int i = 0; i < 25; i++)
      press($urandom_range(0, 15), $urandom_range(4, 6), $urandom_range(3, 4));

    cycles(2 * FRAME);
    check("final entry", int'(entry), m_entry);
    check("final digit_cnt", int'(digit_cnt), m_cnt);
    check("leftover keys", exp_key_q.size(), 0);
    check("leftover results", exp_res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
